// File: rtl/buzzer_seq.sv
// buzzer_seq: melody sequencer that queues CPU note words and replays them as buzzer register writes
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rd, raddr, rdata    slave read port, one cycle latency, rdata holds when rd=0
//   wr, waddr, wdata    slave write port (VER/CTRL/STAT/PUSH/TICK/GAP)
//   m_wr, m_waddr,      registered master write port to the buzzer
//   m_wdata
//   irq                 drain interrupt, present only when BUZZER_SEQ_IRQ_EN is defined
// Each note is written out as divider, target, enable; the buzzer is switched off
// after dur*TICK cycles, followed by an optional GAP*TICK cycles of silence.
module buzzer_seq #(
  parameter int ADDRWIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd,
  input  logic [ADDRWIDTH-1:0] raddr,
  output logic [31:0]          rdata,
  input  logic                 wr,
  input  logic [ADDRWIDTH-1:0] waddr,
  input  logic [31:0]          wdata,
  output logic                 m_wr,
  output logic [ADDRWIDTH-1:0] m_waddr,
  output logic [31:0]          m_wdata
`ifdef BUZZER_SEQ_IRQ_EN
  ,
  output logic                 irq
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [ADDRWIDTH-1:0] A_VER  = ADDRWIDTH'(8'h00);
  localparam logic [ADDRWIDTH-1:0] A_CTRL = ADDRWIDTH'(8'h04);
  localparam logic [ADDRWIDTH-1:0] A_STAT = ADDRWIDTH'(8'h08);
  localparam logic [ADDRWIDTH-1:0] A_PUSH = ADDRWIDTH'(8'h0C);
  localparam logic [ADDRWIDTH-1:0] A_TICK = ADDRWIDTH'(8'h10);
  localparam logic [ADDRWIDTH-1:0] A_GAP  = ADDRWIDTH'(8'h14);
  localparam logic [ADDRWIDTH-1:0] B_EN   = ADDRWIDTH'(8'h04);
  localparam logic [ADDRWIDTH-1:0] B_DIV  = ADDRWIDTH'(8'h08);
  localparam logic [ADDRWIDTH-1:0] B_TAR  = ADDRWIDTH'(8'h0C);

  typedef enum logic [2:0] {IDLE, WR_DIV, WR_TAR, WR_EN, PLAY, WR_OFF, GAP, STOP} state_t;

  state_t          state;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [LW-1:0]   level, level_nx;
  logic            run, ovf, irq_en, rest;
  logic [15:0]     tick, gap, dur, tick_e;
  logic [31:0]     cnt, head, rmux;
  logic            push, flush, full, empty, start, acc, halt;

  always_comb begin
    head     = mem[rptr];
    tick_e   = (tick == 16'h0) ? 16'h1 : tick;
    push     = wr && waddr == A_PUSH;
    flush    = wr && waddr == A_CTRL && wdata[1];
    full     = level == LW'(DEPTH);
    empty    = level == '0;
    start    = state == IDLE && run && !empty && !flush;
    acc      = push && (!full || start);
    halt     = state != IDLE && state != STOP && (!run || flush);
    level_nx = flush ? '0 : level + LW'(acc) - LW'(start);
  end

  always_comb
    rmux = raddr == A_VER  ? 32'h1 :
           raddr == A_CTRL ? {29'h0, irq_en, 1'b0, run} :
           raddr == A_STAT ? {16'h0, 8'(level), 4'h0, ovf, full, empty, state != IDLE} :
           raddr == A_TICK ? {16'h0, tick} :
           raddr == A_GAP  ? {16'h0, gap} : 32'h0;

  always_ff @(posedge clk)
    if (acc) mem[wptr] <= wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      run   <= 1'b0;
      ovf   <= 1'b0;
      tick  <= 16'h1;
      gap   <= 16'h0;
      rdata <= 32'h0;
    end else begin
      wptr  <= flush ? '0 : wptr + AW'(acc);
      rptr  <= flush ? '0 : rptr + AW'(start);
      level <= level_nx;
      if (push && full && !start) ovf <= 1'b1;
      else if (wr && waddr == A_STAT && wdata[3]) ovf <= 1'b0;
      if (wr && waddr == A_CTRL) run <= wdata[0];
      if (wr && waddr == A_TICK) tick <= wdata[15:0];
      if (wr && waddr == A_GAP) gap <= wdata[15:0];
      if (rd) rdata <= rmux;
    end

  // Interval counters load the full cycle count on entry to the write state that
  // opens the interval, so the following write lands exactly that many cycles later.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      m_wr    <= 1'b0;
      m_waddr <= '0;
      m_wdata <= 32'h0;
      rest    <= 1'b0;
      dur     <= 16'h0;
      cnt     <= 32'h0;
    end else begin
      m_wr <= 1'b0;
      if (halt) begin
        state   <= STOP;
        m_wr    <= 1'b1;
        m_waddr <= B_EN;
        m_wdata <= 32'h0;
      end else
        case (state)
          IDLE:
            if (start && head[31:16] != 16'h0) begin
              state   <= WR_DIV;
              rest    <= head[15:0] == 16'h0;
              dur     <= head[31:16];
              m_wr    <= 1'b1;
              m_waddr <= B_DIV;
              m_wdata <= {16'h0, head[15:0]};
            end
          WR_DIV: begin
            state   <= WR_TAR;
            m_wr    <= 1'b1;
            m_waddr <= B_TAR;
            m_wdata <= 32'hFFFF_FFFF;
          end
          WR_TAR: begin
            state   <= WR_EN;
            m_wr    <= 1'b1;
            m_waddr <= B_EN;
            m_wdata <= {31'h0, !rest};
            cnt     <= 32'(dur) * 32'(tick_e);
          end
          WR_EN, PLAY:
            if (cnt <= 32'h1) begin
              state   <= WR_OFF;
              m_wr    <= 1'b1;
              m_waddr <= B_EN;
              m_wdata <= 32'h0;
              cnt     <= 32'(gap) * 32'(tick_e);
            end else begin
              state <= PLAY;
              cnt   <= cnt - 32'h1;
            end
          WR_OFF, GAP:
            if (cnt <= 32'h1) state <= IDLE;
            else begin
              state <= GAP;
              cnt   <= cnt - 32'h1;
            end
          default: state <= IDLE;
        endcase
    end

`ifdef BUZZER_SEQ_IRQ_EN
  logic ret;

  // Skipped zero-duration entries count as a return to IDLE as well.
  always_comb
    ret = state == STOP ||
          (!halt && (state == WR_OFF || state == GAP) && cnt <= 32'h1) ||
          (start && head[31:16] == 16'h0);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr && waddr == A_CTRL) irq_en <= wdata[2];
      if (push || (wr && waddr == A_CTRL && !wdata[2])) irq <= 1'b0;
      else if (ret && level_nx == '0 && irq_en) irq <= 1'b1;
    end
`else
  assign irq_en = 1'b0;
`endif
endmodule

// File: tb/tb_buzzer_seq.sv
// tb_buzzer_seq: randomized self-checking bench for buzzer_seq against a note-level timing model
module tb_buzzer_seq;
  localparam int AW = 5;
  localparam int DEPTH = 8;

  logic clk = 1'b0, rst_n = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [AW-1:0] raddr = '0, waddr = '0, m_waddr;
  logic [31:0] wdata = '0, rdata, m_wdata;
  logic m_wr;
`ifdef BUZZER_SEQ_IRQ_EN
  logic irq;
`endif

  int vectors = 0, miscompares = 0, cyc = 0;
  int exp_c[$];
  logic [AW-1:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [31:0] mq[$];
  logic movf = 1'b0;
  int m_tick = 1, m_gap = 0;

  buzzer_seq #(.ADDRWIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rd(rd), .raddr(raddr), .rdata(rdata),
    .wr(wr), .waddr(waddr), .wdata(wdata),
    .m_wr(m_wr), .m_waddr(m_waddr), .m_wdata(m_wdata)
`ifdef BUZZER_SEQ_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk)
    if (rst_n && m_wr) begin
      if (exp_c.size() == 0) check("unexpected_wr", 32'(m_waddr), 32'hFFFF_FFFF);
      else begin
        check("wr_cycle", cyc, exp_c[0]);
        check("wr_addr", 32'(m_waddr), 32'(exp_a[0]));
        check("wr_data", m_wdata, exp_d[0]);
        void'(exp_c.pop_front());
        void'(exp_a.pop_front());
        void'(exp_d.pop_front());
      end
    end

  task automatic ew(int c, int a, logic [31:0] d);
    exp_c.push_back(c);
    exp_a.push_back(AW'(a));
    exp_d.push_back(d);
  endtask

  // Note-level timing: t is the IDLE cycle that decides on the next entry.
  task automatic sched(input int t0, output int t);
    logic [31:0] e;
    int te, d, g;
    t = t0;
    te = (m_tick == 0) ? 1 : m_tick;
    while (mq.size() > 0) begin
      e = mq.pop_front();
      if (e[31:16] == 16'h0) t = t + 1;
      else begin
        d = int'(e[31:16]) * te;
        g = m_gap * te;
        ew(t + 1, 'h08, {16'h0, e[15:0]});
        ew(t + 2, 'h0C, 32'hFFFF_FFFF);
        ew(t + 3, 'h04, (e[15:0] != 16'h0) ? 32'h1 : 32'h0);
        ew(t + 3 + d, 'h04, 32'h0);
        t = t + 3 + d + ((g > 1) ? g : 1);
      end
    end
  endtask

  task automatic bus_wr(int a, logic [31:0] d);
    wr = 1'b1;
    waddr = AW'(a);
    wdata = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_rd(int a, output logic [31:0] d);
    rd = 1'b1;
    raddr = AW'(a);
    @(negedge clk);
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic push(logic [31:0] d);
    if (mq.size() < DEPTH) mq.push_back(d);
    else movf = 1'b1;
    bus_wr('h0C, d);
  endtask

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic logic [31:0] stat_exp();
    return {16'h0, 8'(mq.size()), 4'h0, movf, mq.size() == DEPTH, mq.size() == 0, 1'b0};
  endfunction

  task automatic set_timing(int tk, int gp);
    bus_wr('h10, 32'(tk));
    bus_wr('h14, 32'(gp));
    m_tick = tk;
    m_gap = gp;
  endtask

  task automatic episode();
    int c, t;
    logic [31:0] r;
    c = cyc;
    bus_wr('h04, 32'h1);
    sched(c + 1, t);
    wait_to(t + 2);
    check("drain", exp_c.size(), 0);
    bus_rd('h08, r);
    check("stat_idle", r, stat_exp());
    bus_wr('h04, 32'h0);
  endtask

  initial begin
    int c, t, f, n;
    logic [31:0] r;
    logic [15:0] dv;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_m_wr", 32'(m_wr), 32'h0);
    check("rst_m_waddr", 32'(m_waddr), 32'h0);
    check("rst_m_wdata", m_wdata, 32'h0);
`ifdef BUZZER_SEQ_IRQ_EN
    check("rst_irq", 32'(irq), 32'h0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    bus_rd('h08, r);
    check("rst_stat", r, 32'h0000_0002);
    bus_rd('h00, r);
    check("ver", r, 32'h1);
    bus_rd('h10, r);
    check("rst_tick", r, 32'h1);
    bus_rd('h04, r);
    check("rst_ctrl", r, 32'h0);
    bus_rd('h1C, r);
    check("unmapped", r, 32'h0);

    // single note pushed while running
    set_timing(4, 0);
    bus_wr('h04, 32'h1);
    c = cyc;
    mq.push_back(32'h0003_0064);
    bus_wr('h0C, 32'h0003_0064);
    sched(c + 1, t);
    wait_to(t + 2);
    check("drain_note", exp_c.size(), 0);
    bus_wr('h04, 32'h0);

    // rest followed by a zero-duration skip
    push(32'h0002_0000);
    push(32'h0000_0050);
    episode();

    // overflow and push/pop on a full FIFO
    set_timing(1, 0);
    for (int i = 0; i < DEPTH + 1; i++) push({16'h1, 16'(i + 1)});
    bus_rd('h08, r);
    check("stat_full", r, stat_exp());
    bus_wr('h08, 32'h8);
    movf = 1'b0;
    bus_rd('h08, r);
    check("stat_ovf_clr", r, stat_exp());
    c = cyc;
    bus_wr('h04, 32'h1);
    mq.push_back(32'h0001_0077);
    bus_wr('h0C, 32'h0001_0077);
    sched(c + 1, t);
    wait_to(t + 2);
    check("drain_full", exp_c.size(), 0);
    bus_rd('h08, r);
    check("stat_pushpop", r, stat_exp());
    bus_wr('h04, 32'h0);

    // flush during PLAY
    for (int i = 0; i < 3; i++) push(32'h000A_0020);
    c = cyc;
    bus_wr('h04, 32'h1);
    t = c + 1;
    ew(t + 1, 'h08, 32'h20);
    ew(t + 2, 'h0C, 32'hFFFF_FFFF);
    ew(t + 3, 'h04, 32'h1);
    f = t + 6;
    ew(f + 1, 'h04, 32'h0);
    mq.delete();
    wait_to(f);
    bus_wr('h04, 32'h3);
    wait_to(f + 4);
    check("drain_flush", exp_c.size(), 0);
    bus_rd('h08, r);
    check("stat_flush", r, 32'h0000_0002);
    bus_wr('h04, 32'h0);

    // run cleared during PLAY keeps the remaining entries
    for (int i = 0; i < 3; i++) push({16'h6, 16'(i + 'h30)});
    c = cyc;
    bus_wr('h04, 32'h1);
    t = c + 1;
    ew(t + 1, 'h08, 32'h30);
    ew(t + 2, 'h0C, 32'hFFFF_FFFF);
    ew(t + 3, 'h04, 32'h1);
    f = t + 5;
    ew(f + 2, 'h04, 32'h0);
    void'(mq.pop_front());
    wait_to(f);
    bus_wr('h04, 32'h0);
    wait_to(f + 5);
    check("drain_stop", exp_c.size(), 0);
    bus_rd('h08, r);
    check("stat_stop", r, stat_exp());
    episode();

    // randomized note lists and timing
    repeat (10) begin
      set_timing($urandom_range(0, 3), $urandom_range(0, 3));
      bus_rd('h10, r);
      check("tick_rb", r, 32'(m_tick));
      bus_rd('h14, r);
      check("gap_rb", r, 32'(m_gap));
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        dv = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        push({16'($urandom_range(0, 3)), dv});
      end
      bus_rd('h08, r);
      check("stat_queued", r, stat_exp());
      episode();
    end

`ifdef BUZZER_SEQ_IRQ_EN
    set_timing(1, 2);
    bus_wr('h04, 32'h5);
    c = cyc;
    mq.push_back(32'h0001_0005);
    bus_wr('h0C, 32'h0001_0005);
    sched(c + 1, t);
    wait_to(t - 1);
    check("irq_gap", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'h1);
    c = cyc;
    mq.push_back(32'h0001_0006);
    bus_wr('h0C, 32'h0001_0006);
    check("irq_push_clr", 32'(irq), 32'h0);
    sched(c + 1, t);
    wait_to(t + 1);
    check("drain_irq", exp_c.size(), 0);
    check("irq_reset", 32'(irq), 32'h1);
    bus_wr('h04, 32'h1);
    check("irq_en_clr", 32'(irq), 32'h0);
    bus_wr('h04, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
